// File: rtl/r2sdf_butterfly_stage.sv
// Radix-2 single-delay-feedback butterfly stage for the 32-point FFT pipeline.
// Ports: clk, rst_n (async low); in_valid, din_r/din_i, state, w_r/w_i in;
//        out_valid, dout_r/dout_i out (registered, 1-cycle latency).
module r2sdf_butterfly_stage #(
    parameter int DW      = 24,
    parameter int DELAY   = 2,
    parameter int TW_FRAC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] din_r,
    input  logic signed [DW-1:0] din_i,
    input  logic [1:0]           state,
    input  logic signed [23:0]   w_r,
    input  logic signed [23:0]   w_i,
    output logic                 out_valid,
    output logic signed [DW-1:0] dout_r,
    output logic signed [DW-1:0] dout_i
);

    // Wide enough for a DW x 24 product plus one bit for the add/sub.
    localparam int PW = DW + 25;

    logic signed [DW-1:0] dl_r [DELAY];
    logic signed [DW-1:0] dl_i [DELAY];

    logic signed [DW-1:0] d_r, d_i;
    logic signed [DW-1:0] sum_r, sum_i;
    logic signed [DW-1:0] dif_r, dif_i;
    logic signed [DW-1:0] push_r, push_i;
    logic signed [DW-1:0] mul_r, mul_i;
    logic signed [PW-1:0] dr_x, di_x, wr_x, wi_x;
    logic signed [PW-1:0] re_full, im_full;

    // Oldest entry sits at the top index.
    assign d_r = dl_r[DELAY-1];
    assign d_i = dl_i[DELAY-1];

    assign sum_r = d_r + din_r;
    assign sum_i = d_i + din_i;
    assign dif_r = d_r - din_r;
    assign dif_i = d_i - din_i;

    assign dr_x = {{(PW-DW){d_r[DW-1]}}, d_r};
    assign di_x = {{(PW-DW){d_i[DW-1]}}, d_i};
    assign wr_x = {{(PW-24){w_r[23]}}, w_r};
    assign wi_x = {{(PW-24){w_i[23]}}, w_i};

    assign re_full = dr_x * wr_x - di_x * wi_x;
    assign im_full = dr_x * wi_x + di_x * wr_x;

    // Arithmetic shift floors toward -inf; keep the low DW bits.
    assign mul_r = DW'(re_full >>> TW_FRAC);
    assign mul_i = DW'(im_full >>> TW_FRAC);

    // Butterfly half feeds back the difference; every other mode stores din.
    always_comb begin
        push_r = din_r;
        push_i = din_i;
        if (state == 2'd2) begin
            push_r = dif_r;
            push_i = dif_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout_r    <= '0;
            dout_i    <= '0;
            for (int i = 0; i < DELAY; i++) begin
                dl_r[i] <= '0;
                dl_i[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                for (int i = DELAY - 1; i > 0; i--) begin
                    dl_r[i] <= dl_r[i-1];
                    dl_i[i] <= dl_i[i-1];
                end
                dl_r[0] <= push_r;
                dl_i[0] <= push_i;
                unique case (state)
                    2'd1: begin
                        dout_r    <= mul_r;
                        dout_i    <= mul_i;
                        out_valid <= 1'b1;
                    end
                    2'd2: begin
                        dout_r    <= sum_r;
                        dout_i    <= sum_i;
                        out_valid <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_r2sdf_butterfly_stage.sv
// Self-checking bench for r2sdf_butterfly_stage: directed cases then random
// traffic, all compared against a queue-based complex-arithmetic model.
module tb_r2sdf_butterfly_stage;

    localparam int DW    = 24;
    localparam int DELAY = 2;
    localparam int FRAC  = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] din_r = '0;
    logic signed [DW-1:0] din_i = '0;
    logic [1:0]           state = 2'd0;
    logic signed [23:0]   w_r = '0;
    logic signed [23:0]   w_i = '0;
    logic                 out_valid;
    logic signed [DW-1:0] dout_r;
    logic signed [DW-1:0] dout_i;

    int total = 0;
    int bad   = 0;

    typedef struct {
        longint r;
        longint i;
    } cplx_t;

    cplx_t  dq[$];
    longint exp_ov, exp_r, exp_i;

    r2sdf_butterfly_stage #(.DW(DW), .DELAY(DELAY), .TW_FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .din_r(din_r), .din_i(din_i), .state(state),
        .w_r(w_r), .w_i(w_i), .out_valid(out_valid),
        .dout_r(dout_r), .dout_i(dout_i)
    );

    always #5 clk = ~clk;

    function automatic longint wrap(input longint x);
        logic signed [DW-1:0] t;
        t = DW'(x);
        return longint'(t);
    endfunction

    function automatic longint rnd24();
        logic signed [23:0] t;
        t = 24'($urandom);
        return longint'(t);
    endfunction

    function automatic void model_reset();
        dq.delete();
        for (int k = 0; k < DELAY; k++) dq.push_back('{0, 0});
        exp_ov = 0;
        exp_r  = 0;
        exp_i  = 0;
    endfunction

    // One accepted-or-stalled clock of the stage, in plain complex arithmetic.
    function automatic void model_step(input bit v, input int st,
                                       input longint ar, input longint ai,
                                       input longint wr, input longint wi);
        cplx_t d;
        exp_ov = 0;
        if (!v) return;
        d = dq.pop_front();
        if (st == 1) begin
            dq.push_back('{ar, ai});
            exp_r  = wrap((d.r * wr - d.i * wi) >>> FRAC);
            exp_i  = wrap((d.r * wi + d.i * wr) >>> FRAC);
            exp_ov = 1;
        end else if (st == 2) begin
            dq.push_back('{wrap(d.r - ar), wrap(d.i - ai)});
            exp_r  = wrap(d.r + ar);
            exp_i  = wrap(d.i + ai);
            exp_ov = 1;
        end else begin
            dq.push_back('{ar, ai});
        end
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        chk({tag, ".ov"}, longint'(out_valid), exp_ov);
        chk({tag, ".r"}, longint'(dout_r), exp_r);
        chk({tag, ".i"}, longint'(dout_i), exp_i);
    endtask

    task automatic step(input string tag, input bit v, input int st,
                        input longint ar, input longint ai,
                        input longint wr, input longint wi);
        in_valid = v;
        state    = 2'(st);
        din_r    = DW'(ar);
        din_i    = DW'(ai);
        w_r      = 24'(wr);
        w_i      = 24'(wi);
        @(posedge clk);
        #1;
        model_step(v, st, ar, ai, wr, wi);
        chk_out(tag);
    endtask

    task automatic fill_case(input string tag);
        step({tag, ".f0"}, 1, 0, 10, 0, 0, 0);
        step({tag, ".f1"}, 1, 0, 20, 0, 0, 0);
        step({tag, ".b0"}, 1, 2, 3, 0, 0, 0);
        chk({tag, ".sum13"}, longint'(dout_r), 13);
        step({tag, ".b1"}, 1, 2, 5, 0, 0, 0);
        chk({tag, ".sum25"}, longint'(dout_r), 25);
    endtask

    initial begin
        model_reset();

        // Reset held with live, toggling input traffic.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            state    = 2'($urandom_range(1, 2));
            din_r    = DW'(rnd24());
            din_i    = DW'(rnd24());
            w_r      = 24'(rnd24());
            w_i      = 24'(rnd24());
            @(posedge clk);
            #1;
            chk_out("rst_hold");
        end
        rst_n = 1'b1;

        // Cleared delay line: first twiddled outputs are zero.
        step("clr0", 1, 1, 0, 0, rnd24(), rnd24());
        step("clr1", 1, 1, 0, 0, rnd24(), rnd24());
        chk("clr1.zero", longint'(dout_r), 0);

        // Fill then butterfly; delay now holds 7, 15.
        fill_case("fill");

        // Twiddle the stored differences.
        step("tw1", 1, 1, 0, 0, 256, 0);
        chk("tw1.r7", longint'(dout_r), 7);
        step("tw2", 1, 1, 0, 0, 0, -256);
        chk("tw2.i-15", longint'(dout_i), -15);

        // Stall in the middle of a butterfly half.
        step("st.f0", 1, 0, 10, 0, 0, 0);
        step("st.f1", 1, 0, 20, 0, 0, 0);
        step("st.b0", 1, 2, 3, 0, 0, 0);
        for (int k = 0; k < 3; k++) step("st.idle", 0, 2, rnd24(), rnd24(), 0, 0);
        chk("st.hold13", longint'(dout_r), 13);
        step("st.b1", 1, 2, 5, 0, 0, 0);
        chk("st.sum25", longint'(dout_r), 25);

        // Positive wrap of the sum; pushed difference 0x7FFFFE.
        step("wr.f0", 1, 0, 24'h7FFFFF, 0, 0, 0);
        step("wr.f1", 1, 0, 24'h7FFFFF, 0, 0, 0);
        step("wr.b0", 1, 2, 1, 0, 0, 0);
        chk("wr.sum", longint'(dout_r), -8388608);
        step("wr.b1", 1, 2, 1, 0, 0, 0);
        step("wr.t0", 1, 1, 0, 0, 256, 0);
        chk("wr.diff", longint'(dout_r), 24'h7FFFFE);
        step("wr.t1", 1, 1, 0, 0, 256, 0);

        // Floor rounding of a negative product.
        step("fl.f0", 1, 0, -3, 0, 0, 0);
        step("fl.f1", 1, 0, -3, 0, 0, 0);
        step("fl.t0", 1, 1, 0, 0, 128, 0);
        chk("fl.r-2", longint'(dout_r), -2);
        chk("fl.i0", longint'(dout_i), 0);

        // Asynchronous reset in the middle of a butterfly half.
        step("mr.f0", 1, 0, 44, 9, 0, 0);
        step("mr.f1", 1, 0, 55, 8, 0, 0);
        step("mr.b0", 1, 2, 1, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_out("mr.async");
        @(negedge clk);
        rst_n = 1'b1;
        fill_case("mr.refill");

        // Random traffic, all modes including reserved, with stalls.
        for (int k = 0; k < 400; k++) begin
            step("rnd", ($urandom_range(0, 4) != 0), int'($urandom_range(0, 3)),
                 rnd24(), rnd24(), rnd24(), rnd24());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
